// File: rtl/sdam_serial_tx.sv
// sdam_serial_tx: FIFO-buffered serializer emitting 27-slot scl/sda frames to the SDAM receiver.
module sdam_serial_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_addr,
    input  logic [15:0]                   in_data,
    output logic                          scl,
    output logic                          sda,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_BITS + 2);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   div;
    logic [26:0]     sh, sh_n;
    logic [4:0]      slot, slot_n;
    logic [GW-1:0]   gap, gap_n;
    logic            sda_n, done_n, pop, push, wrap, fall, idle;
    logic [23:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    assign wrap     = div == DW'(CLK_DIV - 1);
    assign fall     = wrap && scl;
    assign in_ready = fifo_count != (AW + 1)'(FIFO_DEPTH);
    assign push     = in_valid && in_ready;
    assign busy     = state != IDLE;

    always_comb begin
        state_n = state;
        sh_n    = sh;
        slot_n  = slot;
        gap_n   = gap;
        sda_n   = sda;
        done_n  = 1'b0;
        pop     = 1'b0;
        idle    = 1'b0;
        if (fall) begin
            case (state)
                IDLE: idle = 1'b1;
                SEND: begin
                    if (slot == 5'd26) begin
                        done_n = 1'b1;
                        if (GAP_BITS > 0) begin
                            state_n = GAP;
                            gap_n   = '0;
                            sda_n   = 1'b1;
                        end else idle = 1'b1;
                    end else begin
                        sh_n   = sh >> 1;
                        sda_n  = sh[1];
                        slot_n = slot + 5'd1;
                    end
                end
                GAP: if (gap == GW'(GAP_BITS - 1)) idle = 1'b1; else gap_n = gap + 1'b1;
                default: idle = 1'b1;
            endcase
            // Frame start: an entry pushed on this very tick is not yet counted, so it waits a slot.
            if (idle) begin
                pop     = fifo_count != '0;
                state_n = pop ? SEND : IDLE;
                sh_n    = pop ? {1'b1, mem[rd_ptr], 2'b10} : sh;
                sda_n   = !pop;
                slot_n  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            div        <= '0;
            scl        <= 1'b0;
            state      <= IDLE;
            sh         <= '0;
            slot       <= '0;
            gap        <= '0;
            sda        <= 1'b1;
            tx_done    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            div        <= wrap ? '0 : div + 1'b1;
            scl        <= scl ^ wrap;
            state      <= state_n;
            sh         <= sh_n;
            slot       <= slot_n;
            gap        <= gap_n;
            sda        <= sda_n;
            tx_done    <= done_n;
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
        end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_data, in_addr};
endmodule

// File: tb/tb_sdam_serial_tx.sv
// tb_sdam_serial_tx: randomized bench for sdam_serial_tx with a slot-level reference model
// and an independent serial decoder that recovers (addr, data) from the scl/sda lines.
module tb_sdam_serial_tx;
    localparam int CD = 4, DEP = 4, G = 1;

    logic        clk = 0, reset_n = 0, in_valid = 0;
    logic [7:0]  in_addr = 0;
    logic [15:0] in_data = 0;
    logic        in_ready, scl, sda, busy, tx_done;
    logic [2:0]  fifo_count;

    sdam_serial_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEP), .GAP_BITS(G)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .scl(scl), .sda(sda), .busy(busy),
        .tx_done(tx_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic fbit(input logic [23:0] r, input int p);
        logic [26:0] v;
        v = {1'b1, r, 2'b10};
        return v[p];
    endfunction

    // Values present at each rising clk edge
    logic        pv_valid = 0, pv_rst = 1;
    logic [23:0] pv_req = 0;
    always @(posedge clk) begin
        pv_valid = in_valid;
        pv_req   = {in_data, in_addr};
        pv_rst   = !reset_n;
    end

    // Model: n = clocks since reset, pos = frame slot (-1 idle, 27.. = gap slots)
    int          n = 0, pos = -1, frames = 0, dones = 0, dbits = -1;
    logic [23:0] q[$], sent[$], cur = 0, last_dec = 0, exp_req;
    logic [26:0] dv = 0;
    logic        prev_scl = 0, mdone, mpush;
    always @(negedge clk) begin
        mdone = 0;
        if (pv_rst || !reset_n) begin
            n = 0; pos = -1; q.delete(); sent.delete(); dbits = -1; prev_scl = 0;
        end else begin
            n++;
            mpush = pv_valid && q.size() < DEP;
            if (n % (2 * CD) == 0) begin
                if (pos >= 0) begin
                    pos++;
                    mdone = pos == 27;
                    if (pos == 27 + G) pos = -1;
                end
                if (pos < 0 && q.size() > 0) begin
                    cur = q.pop_front();
                    pos = 0;
                end
            end
            if (mpush) begin
                q.push_back(pv_req);
                sent.push_back(pv_req);
            end
        end
        chk("scl", scl, (n / CD) % 2);
        chk("sda", sda, (pos >= 0 && pos < 27) ? fbit(cur, pos) : 1'b1);
        chk("busy", busy, pos >= 0);
        chk("tx_done", tx_done, mdone);
        chk("in_ready", in_ready, q.size() < DEP);
        chk("fifo_count", fifo_count, q.size());
        if (reset_n && !pv_rst) begin
            dones += tx_done;
            if (scl && !prev_scl) begin
                if (dbits < 0) begin
                    if (!sda) begin dbits = 1; dv = 0; end
                end else begin
                    dv[dbits] = sda;
                    dbits++;
                    if (dbits == 27) begin
                        dbits = -1;
                        frames++;
                        last_dec = dv[25:2];
                        exp_req = sent.size() > 0 ? sent.pop_front() : 24'hxxxxxx;
                        chk("dec_pad", dv[1], 1);
                        chk("dec_end", dv[26], 1);
                        chk("dec_frame", dv[25:2], exp_req);
                    end
                end
            end
            prev_scl = scl;
        end
    end

    task automatic push(input logic [7:0] a, input logic [15:0] d);
        int k = 0;
        in_addr = a; in_data = d; in_valid = 1;
        while (!in_ready && k < 3000) begin @(negedge clk); #1; k++; end
        if (k >= 3000) chk("push_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 0;
        in_addr = 8'($urandom); in_data = 16'($urandom);
    endtask

    task automatic wait_frames(input int f);
        int k = 0;
        while (frames < f && k < 20000) begin @(negedge clk); #1; k++; end
        chk("frame_timeout", frames >= f, 1);
    endtask

    initial begin
        int k, base;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_scl", scl, 0); chk("rst_sda", sda, 1); chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0); chk("rst_count", fifo_count, 0);
        reset_n = 1;
        repeat (CD - 1) @(posedge clk);
        #1 chk("scl_before_toggle", scl, 0);
        @(posedge clk); #1 chk("scl_toggle", scl, 1);
        // Single frame
        push(8'hA5, 16'h1234);
        wait_frames(1);
        chk("t2_addr", last_dec[7:0], 8'hA5);
        chk("t2_data", last_dec[23:8], 16'h1234);
        repeat (2 * CD * 2) @(negedge clk);
        #1 chk("t2_dones", dones, 1);
        // Back-to-back requests
        base = frames;
        for (int i = 1; i <= 3; i++) push(8'(i), 16'(i));
        wait_frames(base + 3);
        chk("t3_last", last_dec, {16'h0003, 8'h03});
        // Full FIFO while busy
        base = frames;
        push(8'h10, 16'h1000);
        k = 0;
        while (!busy && k < 100) begin @(negedge clk); #1; k++; end
        for (int i = 1; i <= 4; i++) push(8'(8'h10 + i), 16'(16'h1000 + i));
        chk("t4_count", fifo_count, 4);
        chk("t4_ready", in_ready, 0);
        push(8'h15, 16'h1005);
        push(8'h16, 16'h1006);
        wait_frames(base + 7);
        chk("t4_last", last_dec, {16'h1006, 8'h16});
        // Push on the very tick of a fall_evt while idle and empty
        k = 0;
        while ((pos >= 0 || q.size() > 0 || (n + 1) % (2 * CD) != 0) && k < 1000) begin
            @(negedge clk); #1; k++;
        end
        in_addr = 8'h5A; in_data = 16'hC3C3; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        chk("t5_no_start", sda, 1); chk("t5_idle", busy, 0); chk("t5_count", fifo_count, 1);
        repeat (2 * CD - 1) @(posedge clk);
        #1 chk("t5_still_idle", sda, 1);
        @(posedge clk); #1;
        chk("t5_start", sda, 0); chk("t5_busy", busy, 1);
        wait_frames(frames + 1);
        chk("t5_frame", last_dec, {16'hC3C3, 8'h5A});
        // Reset in the middle of a frame
        push(8'h71, 16'h7171);
        push(8'h72, 16'h7272);
        push(8'h73, 16'h7373);
        k = 0;
        while (!(pos == 15 && cur == {16'h7171, 8'h71}) && k < 2000) begin @(negedge clk); #1; k++; end
        chk("t6_reached_slot15", pos, 15);
        reset_n = 0;
        #1;
        chk("t6_sda", sda, 1); chk("t6_scl", scl, 0); chk("t6_count", fifo_count, 0);
        chk("t6_busy", busy, 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1;
        base = frames;
        push(8'h3C, 16'hBEEF);
        wait_frames(base + 1);
        chk("t6_frame", last_dec, {16'hBEEF, 8'h3C});
        // Random traffic
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            #1 push(8'($urandom), 16'($urandom));
        end
        k = 0;
        while ((sent.size() > 0 || pos >= 0) && k < 20000) begin @(negedge clk); #1; k++; end
        chk("drained", sent.size(), 0);
        chk("final_idle", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
